// File: rtl/glyph_pkg.sv
// Shared definitions for the calculator glyph serializer: glyph codes,
// FSM state encodings and the 5x5 font table.
package glyph_pkg;

    localparam int FONT_W = 5;
    localparam int FONT_H = 5;

    localparam logic [3:0] GLYPH_PLUS  = 4'd10;
    localparam logic [3:0] GLYPH_MINUS = 4'd11;
    localparam logic [3:0] GLYPH_MUL   = 4'd12;
    localparam logic [3:0] GLYPH_DIV   = 4'd13;
    localparam logic [3:0] GLYPH_EQ    = 4'd14;
    localparam logic [3:0] GLYPH_BLANK = 4'd15;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    // Bitmaps are stored top row first, leftmost pixel in the row MSB.
    function automatic logic [FONT_W-1:0] glyph_font(input logic [3:0] code,
                                                     input logic [2:0] row);
        logic [FONT_W*FONT_H-1:0] bitmap;
        bitmap = '0;
        case (code)
            4'd0:        bitmap = 25'b11111_10001_10001_10001_11111;
            4'd1:        bitmap = 25'b00100_01100_00100_00100_01110;
            4'd2:        bitmap = 25'b11111_00001_11111_10000_11111;
            4'd3:        bitmap = 25'b11111_00001_01111_00001_11111;
            4'd4:        bitmap = 25'b10001_10001_11111_00001_00001;
            4'd5:        bitmap = 25'b11111_10000_11111_00001_11111;
            4'd6:        bitmap = 25'b11111_10000_11111_10001_11111;
            4'd7:        bitmap = 25'b11111_00001_00010_00100_00100;
            4'd8:        bitmap = 25'b11111_10001_11111_10001_11111;
            4'd9:        bitmap = 25'b11111_10001_11111_00001_11111;
            GLYPH_PLUS:  bitmap = 25'b00100_00100_11111_00100_00100;
            GLYPH_MINUS: bitmap = 25'b00000_00000_11111_00000_00000;
            GLYPH_MUL:   bitmap = 25'b10101_01110_11111_01110_10101;
            GLYPH_DIV:   bitmap = 25'b00001_00010_00100_01000_10000;
            GLYPH_EQ:    bitmap = 25'b00000_11111_00000_11111_00000;
            default:     bitmap = '0;
        endcase
        if (int'(row) >= FONT_H)
            return '0;
        return bitmap[(FONT_H-1-int'(row))*FONT_W +: FONT_W];
    endfunction

endpackage

// File: rtl/glyph_font_rom.sv
// Combinational glyph code + row to font word lookup; rows beyond the
// glyph height (or beyond the stored font) read as blank.
module glyph_font_rom
    import glyph_pkg::*;
#(
    parameter int GLYPH_W = 5,
    parameter int GLYPH_H = 5,
    parameter int ROW_W   = 3
) (
    input  logic [3:0]         code,
    input  logic [ROW_W-1:0]   row,
    output logic [GLYPH_W-1:0] word
);

    logic [FONT_W-1:0] font_word;

    always_comb begin
        font_word = '0;
        if (int'(row) < GLYPH_H && int'(row) < FONT_H)
            font_word = glyph_font(code, 3'(row));
    end

    // Fit the 5-bit font to the configured row width, left-aligned.
    generate
        if (GLYPH_W == FONT_W) begin : g_exact
            assign word = font_word;
        end else if (GLYPH_W > FONT_W) begin : g_pad
            assign word = {font_word, {(GLYPH_W-FONT_W){1'b0}}};
        end else begin : g_trunc
            assign word = font_word[FONT_W-1 -: GLYPH_W];
        end
    endgenerate

endmodule

// File: rtl/glyph_row_serializer.sv
// Looks up one glyph row and streams it MSB-first, each bit held SCALE_X
// cycles. Define GLYPH_INVERT_EN to add the cursor-highlight invert input.
module glyph_row_serializer
    import glyph_pkg::*;
#(
    parameter int GLYPH_W = 5,
    parameter int GLYPH_H = 5,
    parameter int ROW_W   = 3,
    parameter int SCALE_X = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       glyph_code,
    input  logic [ROW_W-1:0] row,
`ifdef GLYPH_INVERT_EN
    input  logic             invert,
`endif
    output logic             busy,
    output logic             pix_valid,
    output logic             pix_on,
    output logic             done
);

    localparam int BW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int SW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;

    logic [1:0]         state;
    logic [3:0]         code_q;
    logic [ROW_W-1:0]   row_q;
    logic [GLYPH_W-1:0] font_word;
    logic [GLYPH_W-1:0] shreg;
    logic [BW-1:0]      bit_cnt;
    logic [SW-1:0]      scale_cnt;
    logic               last_pix;
    logic               accept;

    glyph_font_rom #(
        .GLYPH_W (GLYPH_W),
        .GLYPH_H (GLYPH_H),
        .ROW_W   (ROW_W)
    ) u_rom (
        .code (code_q),
        .row  (row_q),
        .word (font_word)
    );

    assign accept   = (state == ST_IDLE) && start;
    assign last_pix = (state == ST_SHIFT) && (scale_cnt == '0) && (bit_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state <= ST_FETCH;
                ST_FETCH: state <= ST_SHIFT;
                ST_SHIFT: if (last_pix) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: datapath registers are deliberately not reset; every output is
    // qualified by state, so their contents are don't-care while idle.
    always_ff @(posedge clk) begin
        if (accept) begin
            code_q <= glyph_code;
            row_q  <= row;
        end
        if (state == ST_FETCH) begin
            shreg     <= font_word;
            bit_cnt   <= BW'(GLYPH_W - 1);
            scale_cnt <= SW'(SCALE_X - 1);
        end else if (state == ST_SHIFT) begin
            if (scale_cnt == '0) begin
                if (bit_cnt != '0) begin
                    shreg     <= shreg << 1;
                    bit_cnt   <= bit_cnt - 1'b1;
                    scale_cnt <= SW'(SCALE_X - 1);
                end
            end else begin
                scale_cnt <= scale_cnt - 1'b1;
            end
        end
    end

    assign busy      = (state != ST_IDLE);
    assign pix_valid = (state == ST_SHIFT);
    assign done      = last_pix;

`ifdef GLYPH_INVERT_EN
    logic inv_q;

    always_ff @(posedge clk) begin
        if (accept)
            inv_q <= invert;
    end

    assign pix_on = pix_valid & (shreg[GLYPH_W-1] ^ inv_q);
`else
    assign pix_on = pix_valid & shreg[GLYPH_W-1];
`endif

endmodule

// File: tb/tb_glyph_row_serializer.sv
// Self-checking bench: two serializer instances (SCALE_X=2 and SCALE_X=1)
// share one stimulus stream; a per-instance output schedule model is compared every cycle.
module tb_glyph_row_serializer;

    typedef struct packed {
        logic busy;
        logic valid;
        logic pix;
        logic done;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] glyph_code;
    logic [2:0] row;
    logic       invert;

    logic busy0, pv0, pix0, done0;
    logic busy1, pv1, pix1, done1;

    int n_checks = 0;
    int n_errors = 0;
    bit armed    = 1'b0;

    obs_t q0[$];
    obs_t q1[$];

    int c_valid[2];
    int c_ones[2];
    int c_done[2];
    int c_busy[2];

    always #5 clk = ~clk;

    glyph_row_serializer #(.GLYPH_W(5), .GLYPH_H(5), .ROW_W(3), .SCALE_X(2)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .glyph_code (glyph_code),
        .row        (row),
`ifdef GLYPH_INVERT_EN
        .invert     (invert),
`endif
        .busy       (busy0),
        .pix_valid  (pv0),
        .pix_on     (pix0),
        .done       (done0)
    );

    glyph_row_serializer #(.GLYPH_W(5), .GLYPH_H(5), .ROW_W(3), .SCALE_X(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .glyph_code (glyph_code),
        .row        (row),
`ifdef GLYPH_INVERT_EN
        .invert     (invert),
`endif
        .busy       (busy1),
        .pix_valid  (pv1),
        .pix_on     (pix1),
        .done       (done1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference font: 25-bit bitmap per code, top row in the high bits.
    function automatic logic [4:0] font_row(input logic [3:0] code, input int r);
        logic [24:0] g;
        case (code)
            4'd0:  g = 25'b11111_10001_10001_10001_11111;
            4'd1:  g = 25'b00100_01100_00100_00100_01110;
            4'd2:  g = 25'b11111_00001_11111_10000_11111;
            4'd3:  g = 25'b11111_00001_01111_00001_11111;
            4'd4:  g = 25'b10001_10001_11111_00001_00001;
            4'd5:  g = 25'b11111_10000_11111_00001_11111;
            4'd6:  g = 25'b11111_10000_11111_10001_11111;
            4'd7:  g = 25'b11111_00001_00010_00100_00100;
            4'd8:  g = 25'b11111_10001_11111_10001_11111;
            4'd9:  g = 25'b11111_10001_11111_00001_11111;
            4'd10: g = 25'b00100_00100_11111_00100_00100;
            4'd11: g = 25'b00000_00000_11111_00000_00000;
            4'd12: g = 25'b10101_01110_11111_01110_10101;
            4'd13: g = 25'b00001_00010_00100_01000_10000;
            4'd14: g = 25'b00000_11111_00000_11111_00000;
            default: g = '0;
        endcase
        if (r >= 5)
            return 5'b0;
        return 5'(g >> (5 * (4 - r)));
    endfunction

    // Expected per-cycle outputs after an accepted start: one fetch cycle,
    // then each font bit (left to right) repeated `scale` times.
    task automatic schedule(input int d, input int scale, input logic [3:0] code,
                            input logic [2:0] r, input logic inv);
        logic [4:0] w;
        obs_t e;
        w = font_row(code, int'(r));
        e = '{busy: 1'b1, valid: 1'b0, pix: 1'b0, done: 1'b0};
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        for (int b = 4; b >= 0; b--) begin
            for (int s = 0; s < scale; s++) begin
                e = '{busy: 1'b1, valid: 1'b1, pix: w[b] ^ inv,
                      done: (b == 0 && s == scale - 1)};
                if (d == 0) q0.push_back(e); else q1.push_back(e);
            end
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 2; i++) begin
            c_valid[i] = 0; c_ones[i] = 0; c_done[i] = 0; c_busy[i] = 0;
        end
    endtask

    // One clock: compare this cycle's outputs, then drive the inputs that
    // the next rising edge samples and advance the model accordingly.
    task automatic step(input logic r, input logic s, input logic [3:0] c,
                        input logic [2:0] rw, input logic iv);
        obs_t exp0, exp1, act0, act1;
        bit idle0, idle1;
        logic inv_eff;
        @(negedge clk);
        idle0 = (q0.size() == 0);
        idle1 = (q1.size() == 0);
        if (armed) begin
            exp0 = idle0 ? obs_t'(4'b0) : q0.pop_front();
            exp1 = idle1 ? obs_t'(4'b0) : q1.pop_front();
            act0 = '{busy: busy0, valid: pv0, pix: pix0, done: done0};
            act1 = '{busy: busy1, valid: pv1, pix: pix1, done: done1};
            check("cycle_s2", 32'(act0), 32'(exp0));
            check("cycle_s1", 32'(act1), 32'(exp1));
            c_valid[0] += int'(pv0);  c_ones[0] += int'(pix0);
            c_done[0]  += int'(done0); c_busy[0] += int'(busy0);
            c_valid[1] += int'(pv1);  c_ones[1] += int'(pix1);
            c_done[1]  += int'(done1); c_busy[1] += int'(busy1);
        end
        reset = r; start = s; glyph_code = c; row = rw; invert = iv;
`ifdef GLYPH_INVERT_EN
        inv_eff = iv;
`else
        inv_eff = 1'b0;
`endif
        if (r) begin
            q0.delete();
            q1.delete();
        end else if (s) begin
            if (idle0) schedule(0, 2, c, rw, inv_eff);
            if (idle1) schedule(1, 1, c, rw, inv_eff);
        end
        armed = armed | r;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 3'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; glyph_code = '0; row = '0; invert = 1'b0;
        clr();

        // Reset for 3 cycles, outputs must be quiet.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0, 3'd0, 1'b0);
        check("rst_outputs", {28'b0, busy0, pv0, pix0, done0}, 32'd0);

        // '=' row 1: ten foreground pixels, busy 11 cycles.
        clr();
        step(1'b0, 1'b1, 4'd14, 3'd1, 1'b0);
        idle_steps(13);
        check("eq_r1_valid", c_valid[0], 10);
        check("eq_r1_ones",  c_ones[0],  10);
        check("eq_r1_done",  c_done[0],  1);
        check("eq_r1_busy",  c_busy[0],  11);

        // '=' row 2: ten background pixels.
        clr();
        step(1'b0, 1'b1, 4'd14, 3'd2, 1'b0);
        idle_steps(13);
        check("eq_r2_valid", c_valid[0], 10);
        check("eq_r2_ones",  c_ones[0],  0);
        check("eq_r2_busy",  c_busy[0],  11);

        // '-' on the unscaled instance: row 2 solid, row 0 empty.
        clr();
        step(1'b0, 1'b1, 4'd11, 3'd2, 1'b0);
        idle_steps(13);
        check("min_r2_ones_x1", c_ones[1],  5);
        check("min_r2_busy_x1", c_busy[1],  6);
        check("min_r2_done_x1", c_done[1],  1);
        clr();
        step(1'b0, 1'b1, 4'd11, 3'd0, 1'b0);
        idle_steps(13);
        check("min_r0_valid_x1", c_valid[1], 5);
        check("min_r0_ones_x1",  c_ones[1],  0);

        // Out-of-range row with start held: one row, restart on first idle cycle.
        clr();
        for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 4'd8, 3'd6, 1'b0);
        idle_steps(14);
        check("oor_done", c_done[0],  2);
        check("oor_valid", c_valid[0], 20);
        check("oor_ones", c_ones[0],  0);

        // Reset during the 4th shift cycle: abort, no done, then a clean row.
        clr();
        step(1'b0, 1'b1, 4'd8, 3'd0, 1'b0);
        idle_steps(4);
        step(1'b1, 1'b0, 4'd0, 3'd0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 3'd0, 1'b0);
        check("abort_valid", c_valid[0], 4);
        check("abort_done",  c_done[0],  0);
        check("abort_busy",  32'(busy0), 32'd0);
        clr();
        step(1'b0, 1'b1, 4'd8, 3'd0, 1'b0);
        idle_steps(13);
        check("after_abort_ones", c_ones[0], 10);
        check("after_abort_done", c_done[0], 1);

`ifdef GLYPH_INVERT_EN
        // Inverted blank: solid foreground, quiet around the stream.
        clr();
        step(1'b0, 1'b1, 4'd15, 3'd0, 1'b1);
        idle_steps(13);
        check("inv_blank_ones",  c_ones[0],  10);
        check("inv_blank_valid", c_valid[0], 10);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 2) == 0),
                 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)));
        end
        idle_steps(14);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
